systolic_operand_loader: RTL and testbench

- Write-side feeder for the systolic array: it fills the west (A-row) and north (B-column) operand queues from a single valid/ready word stream, so operands no longer come from memory files.
- It waits until both queues drain, loads A then B, pulses the multiply start, then holds off further loads until the array reports completion.
- It sits between the host/DMA stream and the `SystolicArray` operand queues.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/loader_idx_counter.sv | 36 +++
 rtl/systolic_operand_loader.sv | 124 ++++++++++++
 tb/tb_systolic_operand_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array operand loader.
// Build option: SYSTOLIC_LOADER_TRANSPOSE_B_EN selects column-major B.
package systolic_pkg;

  localparam int N_DEF = 8;
  localparam int IDX_W = $clog2(N_DEF);
  localparam int MAX_N = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_A,
    LOAD_B,
    START,
    RUN
  } loader_state_t;

  function automatic logic [MAX_N-1:0] onehot_idx(input int idx);
    logic [MAX_N-1:0] one;
    one = {{(MAX_N-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/loader_idx_counter.sv
// Row/column beat position counter for the operand loader.
// Column advances per beat; row advances when column wraps.
module loader_idx_counter #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] col_o,
  output logic         last_o
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic col_wrap;
  logic row_wrap;

  assign col_wrap = (col_o == MAX);
  assign row_wrap = (row_o == MAX);
  assign last_o   = col_wrap && row_wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      row_o <= '0;
      col_o <= '0;
    end else if (adv_i) begin
      col_o <= col_wrap ? '0 : col_o + 1'b1;
      if (col_wrap)
        row_o <= row_wrap ? '0 : row_o + 1'b1;
    end
  end

endmodule

// File: rtl/systolic_operand_loader.sv
// Fills west/north systolic operand queues from one valid/ready stream.
// Build option: SYSTOLIC_LOADER_TRANSPOSE_B_EN selects column-major B.
module systolic_operand_loader
  import systolic_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  west_queue_empty_i,
  input  logic                  north_queue_empty_i,
  input  logic                  matrix_mult_complete_i,
  output logic [N-1:0]          west_wr_en_o,
  output logic [DATA_WIDTH-1:0] west_wr_data_o,
  output logic [N-1:0]          north_wr_en_o,
  output logic [DATA_WIDTH-1:0] north_wr_data_o,
  output logic                  start_matrix_mult_o,
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  loader_state_t state;

  logic [IW-1:0]    row;
  logic [IW-1:0]    col;
  logic             last;
  logic             beat;
  logic [MAX_N-1:0] row_oh;
  logic [MAX_N-1:0] col_oh;
  logic [N-1:0]     west_sel;
  logic [N-1:0]     north_sel;

  assign s_ready_o = (state == LOAD_A) || (state == LOAD_B);
  assign beat      = s_valid_i && s_ready_o;
  assign busy_o    = (state != IDLE);

  // Counters sit at (0,0) outside the load states, so every entry starts clean.
  loader_idx_counter #(
    .N (N),
    .W (IW)
  ) u_idx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (!s_ready_o),
    .adv_i  (beat),
    .row_o  (row),
    .col_o  (col),
    .last_o (last)
  );

  always_comb begin
    row_oh   = onehot_idx(int'(row));
    col_oh   = onehot_idx(int'(col));
    west_sel = row_oh[N-1:0];
`ifdef SYSTOLIC_LOADER_TRANSPOSE_B_EN
    north_sel = row_oh[N-1:0];
`else
    north_sel = col_oh[N-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= IDLE;
      west_wr_en_o        <= '0;
      west_wr_data_o      <= '0;
      north_wr_en_o       <= '0;
      north_wr_data_o     <= '0;
      start_matrix_mult_o <= 1'b0;
      error_o             <= 1'b0;
    end else begin
      west_wr_en_o        <= '0;
      north_wr_en_o       <= '0;
      start_matrix_mult_o <= 1'b0;
      error_o             <= load_start_i && (state != IDLE);
      unique case (state)
        IDLE: begin
          if (load_start_i)
            state <= WAIT_EMPTY;
        end
        WAIT_EMPTY: begin
          if (west_queue_empty_i && north_queue_empty_i)
            state <= LOAD_A;
        end
        LOAD_A: begin
          if (beat) begin
            west_wr_en_o   <= west_sel;
            west_wr_data_o <= s_data_i;
            if (last)
              state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (beat) begin
            north_wr_en_o   <= north_sel;
            north_wr_data_o <= s_data_i;
            if (last) begin
              state               <= START;
              start_matrix_mult_o <= 1'b1;
            end
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (matrix_mult_complete_i)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Directed bench for systolic_operand_loader with a per-queue scoreboard.
// Honours SYSTOLIC_LOADER_TRANSPOSE_B_EN for the north queue mapping.
module tb_systolic_operand_loader;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NB = N * N;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          load_start_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic          west_queue_empty_i = 1'b1;
  logic          north_queue_empty_i = 1'b1;
  logic          matrix_mult_complete_i = 1'b0;
  logic [N-1:0]  west_wr_en_o;
  logic [DW-1:0] west_wr_data_o;
  logic [N-1:0]  north_wr_en_o;
  logic [DW-1:0] north_wr_data_o;
  logic          start_matrix_mult_o;
  logic          busy_o;
  logic          error_o;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] wq[N][$];
  logic [DW-1:0] nq[N][$];
  logic [DW-1:0] wcap[N][$];
  logic [DW-1:0] ncap[N][$];

  int strobes = 0;
  int starts = 0;
  int errs = 0;
  int cyc = 0;
  int first_cyc = -1;
  int start_cyc = -1;
  int hot;
  logic rst_prev = 1'b1;
  logic [DW-1:0] prev_w = '0;
  logic [DW-1:0] prev_n = '0;
  logic [DW-1:0] exp_v;

  always #5 clk = ~clk;

  systolic_operand_loader #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst_i),
    .load_start_i           (load_start_i),
    .s_data_i               (s_data_i),
    .s_valid_i              (s_valid_i),
    .s_ready_o              (s_ready_o),
    .west_queue_empty_i     (west_queue_empty_i),
    .north_queue_empty_i    (north_queue_empty_i),
    .matrix_mult_complete_i (matrix_mult_complete_i),
    .west_wr_en_o           (west_wr_en_o),
    .west_wr_data_o         (west_wr_data_o),
    .north_wr_en_o          (north_wr_en_o),
    .north_wr_data_o        (north_wr_data_o),
    .start_matrix_mult_o    (start_matrix_mult_o),
    .busy_o                 (busy_o),
    .error_o                (error_o)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // A[r][c] = r*8+c, B[r][c] = 0x100+r*8+c, streamed A then B.
  function automatic logic [DW-1:0] beat_val(input int i);
    if (i < NB) return DW'(i);
    return DW'(32'h100 + i - NB);
  endfunction

  task automatic model_load(input int nbeats);
    for (int q = 0; q < N; q++) begin
      wq[q].delete();
      nq[q].delete();
      wcap[q].delete();
      ncap[q].delete();
    end
    strobes = 0;
    starts = 0;
    errs = 0;
    first_cyc = -1;
    start_cyc = -1;
    for (int i = 0; i < nbeats; i++) begin
      int k;
      int r;
      int c;
      k = i % NB;
      r = k / N;
      c = k % N;
      if (i < NB)
        wq[r].push_back(beat_val(i));
`ifdef SYSTOLIC_LOADER_TRANSPOSE_B_EN
      else
        nq[r].push_back(beat_val(i));
`else
      else
        nq[c].push_back(beat_val(i));
`endif
    end
  endtask

  function automatic int model_left();
    int s;
    s = 0;
    for (int q = 0; q < N; q++) s += wq[q].size() + nq[q].size();
    return s;
  endfunction

  always @(negedge clk) begin
    cyc++;
    hot = $countones(west_wr_en_o) + $countones(north_wr_en_o);
    if (hot != 0) begin
      chk("one_strobe", hot, 1);
      if (first_cyc < 0) first_cyc = cyc;
    end
    for (int q = 0; q < N; q++) begin
      if (west_wr_en_o[q]) begin
        strobes++;
        wcap[q].push_back(west_wr_data_o);
        if (wq[q].size() == 0) begin
          chk($sformatf("west%0d_extra", q), west_wr_data_o, 64'hdead);
        end else begin
          exp_v = wq[q].pop_front();
          chk($sformatf("west%0d_data", q), west_wr_data_o, exp_v);
        end
      end
      if (north_wr_en_o[q]) begin
        strobes++;
        ncap[q].push_back(north_wr_data_o);
        if (nq[q].size() == 0) begin
          chk($sformatf("north%0d_extra", q), north_wr_data_o, 64'hdead);
        end else begin
          exp_v = nq[q].pop_front();
          chk($sformatf("north%0d_data", q), north_wr_data_o, exp_v);
        end
      end
    end
    if (!rst_prev) begin
      if (west_wr_en_o == '0) chk("west_hold", west_wr_data_o, prev_w);
      if (north_wr_en_o == '0) chk("north_hold", north_wr_data_o, prev_n);
    end
    if (start_matrix_mult_o) begin
      starts++;
      start_cyc = cyc;
      chk("start_with_last_write",
          {31'd0, north_wr_en_o != '0, strobes}, {32'd1, 2 * NB});
    end
    if (error_o) errs++;
    prev_w = west_wr_data_o;
    prev_n = north_wr_data_o;
    rst_prev = rst_i;
  end

  task automatic pulse_start();
    load_start_i = 1'b1;
    @(posedge clk);
    #1;
    load_start_i = 1'b0;
  endtask

  task automatic drive(input int cnt, input bit gaps, input int err_at);
    int i;
    int n;
    bit acc;
    bit err_done;
    i = 0;
    n = 0;
    err_done = 1'b0;
    while (i < cnt && n < 2000) begin
      s_valid_i = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      s_data_i = s_valid_i ? beat_val(i) : DW'($urandom);
      load_start_i = (i == err_at) && !err_done;
      if (load_start_i) err_done = 1'b1;
      acc = s_valid_i && s_ready_o;
      @(posedge clk);
      n++;
      if (acc) i++;
      #1;
    end
    s_valid_i = 1'b0;
    load_start_i = 1'b0;
    if (i < cnt) chk("drive_timeout", i, cnt);
  endtask

  task automatic finish_run();
    repeat (3) @(posedge clk);
    #1;
    chk("busy_in_run", busy_o, 1);
    matrix_mult_complete_i = 1'b1;
    @(posedge clk);
    #1;
    matrix_mult_complete_i = 1'b0;
    chk("idle_after_complete", busy_o, 0);
  endtask

  task automatic check_load(input string tag);
    chk({tag, "_strobes"}, strobes, 2 * NB);
    chk({tag, "_starts"}, starts, 1);
    chk({tag, "_model_drained"}, model_left(), 0);
    chk({tag, "_w3_len"}, wcap[3].size(), N);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_w3_%0d", tag, k), wcap[3][k], 24 + k);
    chk({tag, "_n5_len"}, ncap[5].size(), N);
`ifdef SYSTOLIC_LOADER_TRANSPOSE_B_EN
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_n5_%0d", tag, k), ncap[5][k], 32'h128 + k);
    chk({tag, "_beat9_q1"}, ncap[1][1], 32'h109);
    chk({tag, "_beat10_q1"}, ncap[1][2], 32'h10A);
`else
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_n5_%0d", tag, k), ncap[5][k], 32'h105 + 8 * k);
    chk({tag, "_beat9_q1"}, ncap[1][1], 32'h109);
    chk({tag, "_beat10_q2"}, ncap[2][1], 32'h10A);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("rst_west_en", west_wr_en_o, 0);
    chk("rst_north_en", north_wr_en_o, 0);
    chk("rst_west_data", west_wr_data_o, 0);
    chk("rst_north_data", north_wr_data_o, 0);
    chk("rst_start", start_matrix_mult_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_ready", s_ready_o, 0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    model_load(2 * NB);
    pulse_start();
    drive(2 * NB, 1'b0, -1);
    finish_run();
    check_load("full");
    chk("full_latency", start_cyc - first_cyc, 2 * NB - 1);
    chk("full_errs", errs, 0);

    model_load(2 * NB);
    pulse_start();
    drive(2 * NB, 1'b1, -1);
    finish_run();
    check_load("gaps");

    model_load(2 * NB);
    west_queue_empty_i = 1'b0;
    pulse_start();
    repeat (20) begin
      @(posedge clk);
      #1;
      chk("wait_ready_low", s_ready_o, 0);
      chk("wait_busy", busy_o, 1);
    end
    chk("wait_no_strobes", strobes, 0);
    west_queue_empty_i = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", s_ready_o, 1);
    drive(2 * NB, 1'b0, -1);
    finish_run();
    check_load("wait");

    model_load(2 * NB);
    pulse_start();
    drive(2 * NB, 1'b0, NB + 16);
    finish_run();
    chk("illegal_errs", errs, 1);
    chk("illegal_strobes", strobes, 2 * NB);
    chk("illegal_starts", starts, 1);

    model_load(40);
    pulse_start();
    drive(40, 1'b0, -1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_west_en", west_wr_en_o, 0);
    chk("midrst_north_en", north_wr_en_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", s_ready_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_idle", busy_o, 0);
    chk("midrst_strobes", strobes, 40);
    chk("midrst_starts", starts, 0);
    chk("midrst_model_drained", model_left(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
